shared_counter_sched: RTL and testbench

Round-robin scheduler that shares one internal up-counter between NREQ requesters.
- Each requester asks for a timed interval of len+1 clk cycles.
- The scheduler grants one requester at a time, clears and runs the counter to that requester's target, then pulses done.
- Sits between interval-timing clients and the counter datapath. The counter is a synchronous binary up-counter with clear.

---
 rtl/shared_counter_sched_if.sv | 28 ++
 rtl/shared_counter_sched.sv | 159 +++++++++++++++
 tb/tb_shared_counter_sched.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_counter_sched_if.sv
`default_nettype none
// ============================================================================
// shared_counter_sched_if : requester-side bus of the shared counter scheduler
// Rev 1.0
// ============================================================================
interface shared_counter_sched_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [CW-1:0]      count;
    logic [NREQ-1:0]    done;
    logic               abort;

    modport master (
        output req, len,
        input  grant, busy, count, done, abort
    );

    modport slave (
        input  req, len,
        output grant, busy, count, done, abort
    );
endinterface
`default_nettype wire

// File: rtl/shared_counter_sched.sv
`default_nettype none
// ============================================================================
// shared_counter_sched : round-robin scheduler sharing one up-counter among
// NREQ interval requesters. Optional macro SHARED_CNT_B2B_EN: back-to-back grants.
// Rev 1.0
// ============================================================================
module shared_counter_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input wire clk,
    input wire rst,
    shared_counter_sched_if.slave bus
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic              r_abort;
    logic              r_busy;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_target;
    logic [c_IW-1:0]   r_gidx;
    logic [c_IW-1:0]   r_rr_ptr;

    logic [NREQ-1:0]   w_arb_req;
    logic [c_IW-1:0]   w_arb_base;
    logic [c_IW-1:0]   w_cand;
    logic [c_IW-1:0]   w_arb_idx;
    logic              w_arb_valid;
    logic [CW-1:0]     w_arb_len;
    logic [NREQ-1:0]   w_arb_onehot;
    logic              w_req_g;

    // In DONE the search starts after the requester just served and skips it.
    always_comb begin
        w_arb_req  = bus.req;
        w_arb_base = r_rr_ptr;
        if (r_state == S_DONE) begin
            w_arb_req  = bus.req & ~r_grant;
            w_arb_base = r_gidx;
        end
    end

    always_comb begin
        w_arb_valid = 1'b0;
        w_arb_idx   = '0;
        w_cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_IW'((int'(w_arb_base) + k) % NREQ);
            if (!w_arb_valid && w_arb_req[w_cand]) begin
                w_arb_valid = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_arb_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_idx == c_IW'(i)) begin
                w_arb_len = bus.len[i*CW +: CW];
            end
        end
    end

    assign w_arb_onehot = NREQ'(1) << w_arb_idx;
    assign w_req_g      = |(bus.req & r_grant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_abort  <= 1'b0;
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_target <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= c_IW'(NREQ - 1);
        end else begin
            r_done  <= '0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_valid) begin
                        r_state  <= S_COUNT;
                        r_grant  <= w_arb_onehot;
                        r_gidx   <= w_arb_idx;
                        r_target <= w_arb_len;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_COUNT: begin
                    // Abort wins over a completion landing in the same cycle.
                    if (!w_req_g) begin
                        r_state  <= S_IDLE;
                        r_grant  <= '0;
                        r_abort  <= 1'b1;
                        r_count  <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= r_gidx;
                    end else if (r_count == r_target) begin
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_DONE: begin
                    r_rr_ptr <= r_gidx;
`ifdef SHARED_CNT_B2B_EN
                    if (w_arb_valid) begin
                        r_state  <= S_COUNT;
                        r_grant  <= w_arb_onehot;
                        r_gidx   <= w_arb_idx;
                        r_target <= w_arb_len;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end
`else
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant = r_grant;
    assign bus.done  = r_done;
    assign bus.abort = r_abort;
    assign bus.busy  = r_busy;
    assign bus.count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_shared_counter_sched.sv
`default_nettype none
// ============================================================================
// tb_shared_counter_sched : scoreboard bench for shared_counter_sched
// Rev 1.0
// ============================================================================
module tb_shared_counter_sched;

    localparam int NREQ = 4;
    localparam int CW   = 4;
`ifdef SHARED_CNT_B2B_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];
    int   done_q[$];

    shared_counter_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

    shared_counter_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        bus.req = '0;
        bus.len = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset();
        bus.req = '0;
        bus.len = '0;
        rst     = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
        total++; if (bus.done  !== 4'b0000) begin bad++; $display("FAIL reset_done: got %b want 0000", bus.done); end
        total++; if (bus.abort !== 1'b0)    begin bad++; $display("FAIL reset_abort: got %b want 0", bus.abort); end
        total++; if (bus.busy  !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.count !== 4'd0)    begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_no_req_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        bit got;
        int e;
        do_reset();
        for (int v = 0; v <= 3; v++) exp_q.push_back(v);
        bus.len[0 +: CW] = 4'd3;
        bus.req = 4'b0001;
        @(negedge clk);
        total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", bus.grant); end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus.done != 0) got = 1'b1;
            else if (bus.busy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                total++; if (int'(bus.count) !== e) begin bad++; $display("FAIL single_count: got %0d want %0d", bus.count, e); end
            end
            if (!got) @(negedge clk);
        end
        total++; if (!got) begin bad++; $display("FAIL single_timeout: got no done want done"); end
        total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL single_done: got %b want 0001", bus.done); end
        total++; if (bus.count !== 4'd3)   begin bad++; $display("FAIL single_done_count: got %0d want 3", bus.count); end
        total++; if (exp_q.size() != 0)    begin bad++; $display("FAIL single_short: got %0d leftover want 0", exp_q.size()); end
        bus.req = '0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
        total++; if (bus.done !== 4'b0000) begin bad++; $display("FAIL single_done_width: got %b want 0000", bus.done); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] prev;
        int ndone;
        int e;
        do_reset();
        exp_q  = '{1, 2, 4, 8, 1};
        done_q = '{1, 2, 4, 8, 1};
        bus.len = '0;
        bus.req = 4'b1111;
        prev  = '0;
        ndone = 0;
        for (int c = 0; c < 60 && ndone < 5; c++) begin
            @(negedge clk);
            total++; if ($countones(bus.grant) > 1 || (bus.done != 0 && bus.abort)) begin bad++; $display("FAIL rr_exclusive: got grant=%b done=%b abort=%b want onehot no abort", bus.grant, bus.done, bus.abort); end
            if (bus.grant != 0 && bus.grant != prev) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                total++; if (int'(bus.grant) !== e) begin bad++; $display("FAIL rr_grant: got %b want %b", bus.grant, e[3:0]); end
            end
            prev = bus.grant;
            if (bus.done != 0) begin
                e = (done_q.size() > 0) ? done_q.pop_front() : 0;
                total++; if (int'(bus.done) !== e) begin bad++; $display("FAIL rr_done: got %b want %b", bus.done, e[3:0]); end
                ndone++;
            end
        end
        bus.req = '0;
        total++; if (ndone != 5) begin bad++; $display("FAIL rr_timeout: got %0d dones want 5", ndone); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_grants_missing: got %0d leftover want 0", exp_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit reached;
        bit got;
        int e;
        do_reset();
        for (int v = 0; v <= 5; v++) exp_q.push_back(v);
        bus.len[0 +: CW] = 4'd15;
        bus.req = 4'b0001;
        reached = 1'b0;
        for (int c = 0; c < 30 && !reached; c++) begin
            @(negedge clk);
            if (bus.busy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                total++; if (int'(bus.count) !== e) begin bad++; $display("FAIL abort_count: got %0d want %0d", bus.count, e); end
                if (bus.count == 4'd5) reached = 1'b1;
            end
        end
        total++; if (!reached) begin bad++; $display("FAIL abort_timeout: got no count 5 want count 5"); end
        bus.req = '0;
        @(negedge clk);
        total++; if (bus.abort !== 1'b1)    begin bad++; $display("FAIL abort_pulse: got %b want 1", bus.abort); end
        total++; if (bus.done  !== 4'b0000) begin bad++; $display("FAIL abort_no_done: got %b want 0000", bus.done); end
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL abort_grant: got %b want 0000", bus.grant); end
        total++; if (bus.count !== 4'd0)    begin bad++; $display("FAIL abort_count_clr: got %0d want 0", bus.count); end
        total++; if (bus.busy  !== 1'b0)    begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        bus.len[CW +: CW] = 4'd0;
        bus.req = 4'b0011;
        @(negedge clk);
        total++; if (bus.abort !== 1'b0)    begin bad++; $display("FAIL abort_one_cycle: got %b want 0", bus.abort); end
        total++; if (bus.grant !== 4'b0010) begin bad++; $display("FAIL abort_next_rr: got %b want 0010", bus.grant); end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.done != 0) got = 1'b1;
        end
        total++; if (bus.done !== 4'b0010) begin bad++; $display("FAIL abort_next_done: got %b want 0010", bus.done); end
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_len_zero();
        int e;
        do_reset();
        done_q = '{0, 1};
        bus.len[0 +: CW] = 4'd0;
        bus.req = 4'b0001;
        @(negedge clk);
        total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL len0_grant: got %b want 0001", bus.grant); end
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            e = done_q.pop_front();
            total++; if (int'(bus.done) !== e) begin bad++; $display("FAIL len0_done_c%0d: got %b want %b", c, bus.done, e[3:0]); end
            total++; if (bus.count !== 4'd0)   begin bad++; $display("FAIL len0_count_c%0d: got %0d want 0", c, bus.count); end
        end
        bus.req = '0;
        @(negedge clk);
        total++; if (bus.done !== 4'b0000) begin bad++; $display("FAIL len0_done_clr: got %b want 0000", bus.done); end
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL len0_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_rst_mid();
        bit got;
        bit reached;
        do_reset();
        bus.len[0 +: CW] = 4'd0;
        bus.req = 4'b0001;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.done != 0) got = 1'b1;
        end
        total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL rstmid_first_done: got %b want 0001", bus.done); end
        bus.len[0 +: CW] = 4'd15;
        reached = 1'b0;
        for (int c = 0; c < 30 && !reached; c++) begin
            @(negedge clk);
            if (bus.busy && bus.count == 4'd7) reached = 1'b1;
        end
        total++; if (!reached) begin bad++; $display("FAIL rstmid_timeout: got no count 7 want count 7"); end
        bus.req = 4'b0101;
        bus.len[0 +: CW]    = 4'd2;
        bus.len[2*CW +: CW] = 4'd0;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL rstmid_grant: got %b want 0000", bus.grant); end
        total++; if (bus.count !== 4'd0)    begin bad++; $display("FAIL rstmid_count: got %0d want 0", bus.count); end
        total++; if (bus.busy  !== 1'b0)    begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 4'b0000 || bus.abort !== 1'b0) begin bad++; $display("FAIL rstmid_pulses: got done=%b abort=%b want 0000 0", bus.done, bus.abort); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL rstmid_ptr: got %b want 0001", bus.grant); end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.done != 0) got = 1'b1;
        end
        total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL rstmid_done: got %b want 0001", bus.done); end
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit got;
        bit found;
        int gaps;
        int e;
        do_reset();
        done_q = '{1, 2};
        bus.len[0 +: CW]  = 4'd2;
        bus.len[CW +: CW] = 4'd2;
        bus.req = 4'b0011;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.done != 0) got = 1'b1;
        end
        e = done_q.pop_front();
        total++; if (int'(bus.done) !== e) begin bad++; $display("FAIL b2b_done0: got %b want %b", bus.done, e[3:0]); end
        gaps  = 0;
        found = 1'b0;
        for (int c = 0; c < 5 && !found; c++) begin
            @(negedge clk);
            if (bus.grant == 4'b0010) found = 1'b1;
            else if (bus.grant == 4'b0000) gaps++;
        end
        total++; if (!found)         begin bad++; $display("FAIL b2b_grant1: got %b want 0010", bus.grant); end
        total++; if (gaps != EXP_GAP) begin bad++; $display("FAIL b2b_gap: got %0d idle cycles want %0d", gaps, EXP_GAP); end
        bus.req = 4'b0010;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.done != 0) got = 1'b1;
        end
        e = done_q.pop_front();
        total++; if (int'(bus.done) !== e) begin bad++; $display("FAIL b2b_done1: got %b want %b", bus.done, e[3:0]); end
        bus.req = '0;
        @(negedge clk);
    endtask

    initial begin
        bus.req = '0;
        bus.len = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_len_zero();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
